// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg -- shared types and constants for the game outcome controller.
//   game_state_t : top-level game state encoding (IDLE, PLAY, WIN, LOSE)
//   CLK_HZ       : nominal pixel/system clock frequency (31.5 MHz)
//   bcd_inc      : 4-digit BCD increment, wraps 9999 -> 0000
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int unsigned CLK_HZ = 31_500_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_state_t;

  // Ripple a +1 through four BCD digits; a digit at 9 rolls to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_outcome_rise_edge.sv
// ---------------------------------------------------------------------------
// rise_edge -- registered rising-edge detector.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   d     : level input (already synchronous and debounced)
//   rise  : high for the one cycle in which d is high and was low last cycle
// RESET_VAL sets the history register value during reset. Resetting it to 1
// means a level that is already high when reset releases is not seen as an
// edge.
// ---------------------------------------------------------------------------
module rise_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_prev_reg <= RESET_VAL;
    end else begin
      d_prev_reg <= d;
    end
  end

  assign rise = d & ~d_prev_reg;

endmodule

// File: rtl/game_outcome.sv
// ---------------------------------------------------------------------------
// game_outcome -- game state controller: IDLE -> PLAY -> WIN/LOSE -> IDLE.
//   clk           : system clock, all state changes on rising edge
//   rst           : asynchronous active-low reset
//   start         : debounced start pushbutton level (edge-detected inside)
//   alien_hit     : one-cycle pulse per alien destroyed
//   player_hit    : one-cycle pulse per hit on the player ship
//   aliens_landed : level, aliens reached the player row
//   game_active   : high in PLAY
//   winner        : high for the whole of WIN
//   loser         : high for the whole of LOSE
//   lives         : remaining lives
//   aliens_left   : aliens not yet destroyed
//   score         : (only with GAME_OUTCOME_SCORE_EN) 4-digit BCD score
// Optional feature macro: GAME_OUTCOME_SCORE_EN adds the score output.
// ---------------------------------------------------------------------------
module game_outcome
  import game_pkg::*;
#(
  parameter int NUM_ALIENS  = 40,
  parameter int NUM_LIVES   = 3,
  parameter int HOLD_CYCLES = 63_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        alien_hit,
  input  logic        player_hit,
  input  logic        aliens_landed,
`ifdef GAME_OUTCOME_SCORE_EN
  output logic [15:0] score,
`endif
  output logic        game_active,
  output logic        winner,
  output logic        loser,
  output logic [1:0]  lives,
  output logic [7:0]  aliens_left
);

  localparam logic [7:0]  ALIENS_INIT = 8'(NUM_ALIENS);
  localparam logic [1:0]  LIVES_INIT  = 2'(NUM_LIVES);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);

  game_state_t state_reg;
  logic [31:0] hold_cnt_reg;
  logic        start_rise;

  logic        alien_take;
  logic        player_take;
  logic [7:0]  aliens_next;
  logic [1:0]  lives_next;
  logic        to_lose;
  logic        to_win;

  rise_edge #(
    .RESET_VAL(1'b1)
  ) u_start_edge (
    .clk (clk),
    .rst (rst),
    .d   (start),
    .rise(start_rise)
  );

  // Hit bookkeeping for PLAY. Counters saturate at 0; the terminal
  // conditions look at the would-be values so the outcome lands on the same
  // edge that consumes the final hit. Losing has priority over winning.
  always_comb begin
    alien_take  = alien_hit && (aliens_left != 8'd0);
    player_take = player_hit && (lives != 2'd0);
    aliens_next = aliens_left - {7'd0, alien_take};
    lives_next  = lives - {1'b0, player_take};
    to_lose     = (player_take && (lives_next == 2'd0)) || aliens_landed;
    to_win      = alien_take && (aliens_next == 8'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 32'd0;
      game_active  <= 1'b0;
      winner       <= 1'b0;
      loser        <= 1'b0;
      lives        <= 2'd0;
      aliens_left  <= 8'd0;
`ifdef GAME_OUTCOME_SCORE_EN
      score        <= 16'h0000;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_rise) begin
            state_reg   <= PLAY;
            game_active <= 1'b1;
            aliens_left <= ALIENS_INIT;
            lives       <= LIVES_INIT;
`ifdef GAME_OUTCOME_SCORE_EN
            score       <= 16'h0000;
`endif
          end
        end

        PLAY: begin
          aliens_left <= aliens_next;
          lives       <= lives_next;
`ifdef GAME_OUTCOME_SCORE_EN
          if (alien_take) begin
            score <= bcd_inc(score);
          end
`endif
          if (to_lose) begin
            state_reg    <= LOSE;
            game_active  <= 1'b0;
            loser        <= 1'b1;
            hold_cnt_reg <= 32'd0;
          end else if (to_win) begin
            state_reg    <= WIN;
            game_active  <= 1'b0;
            winner       <= 1'b1;
            hold_cnt_reg <= 32'd0;
          end
        end

        WIN, LOSE: begin
          // Start edges before the hold expires are simply dropped.
          if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 32'd1;
          end else if (start_rise) begin
            state_reg <= IDLE;
            winner    <= 1'b0;
            loser     <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/game_outcome.md
GAME_OUTCOME -- requirements
Module: game_outcome

Interface
REQ-001 SHALL have parameter NUM_ALIENS, default 40, aliens to destroy for a win (1..255).
REQ-002 SHALL have parameter NUM_LIVES, default 3, player lives per game (1..3).
REQ-003 SHALL have parameter HOLD_CYCLES, default 63000000, cycles an end screen stays before restart is accepted (2 s at 31.5 MHz).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  level from start pushbutton, already debounced.
REQ-007 SHALL have port alien_hit  input  1  one-cycle pulse per alien destroyed.
REQ-008 SHALL have port player_hit  input  1  one-cycle pulse per hit on player ship.
REQ-009 SHALL have port aliens_landed  input  1  level, aliens reached player row.
REQ-010 SHALL have port game_active  output  1  high in PLAY only.
REQ-011 SHALL have port winner  output  1  high in WIN; drives the win-banner sprite.
REQ-012 SHALL have port loser  output  1  high in LOSE.
REQ-013 SHALL have port lives  output  2  remaining lives.
REQ-014 SHALL have port aliens_left  output  8  aliens not yet destroyed.

Function
REQ-015 SHALL implement states IDLE, PLAY, WIN, LOSE; all outputs registered.
REQ-016 SHALL detect start rising edge internally; level-held start SHALL not retrigger.
REQ-017 IDLE->PLAY on start edge: load aliens_left=NUM_ALIENS, lives=NUM_LIVES, same edge.
REQ-018 In PLAY, alien_hit SHALL decrement aliens_left by 1, saturating at 0.
REQ-019 In PLAY, player_hit SHALL decrement lives by 1, saturating at 0.
REQ-020 PLAY->LOSE when lives would reach 0 or aliens_landed high; outputs update the cycle after the causing input.
REQ-021 PLAY->WIN when aliens_left would reach 0; outputs update the cycle after the final alien_hit.
REQ-022 Simultaneous final alien_hit and final player_hit (or aliens_landed) SHALL go to LOSE; both counters still decrement.
REQ-023 alien_hit/player_hit outside PLAY SHALL be ignored.
REQ-024 On WIN/LOSE entry a 32-bit hold counter SHALL clear and count to HOLD_CYCLES-1; then state SHALL hold.
REQ-025 WIN/LOSE->IDLE only on a start edge after hold expiry; earlier edges discarded, not queued.
REQ-026 winner SHALL stay high for all of WIN (banner motion needs a continuous level), low the cycle IDLE is entered.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, game_active=0, winner=0, loser=0, lives=0, aliens_left=0, hold counter=0, edge-detect history=1.
REQ-028 Edge history reset to 1 SHALL ensure start held through reset release does not launch a game.
REQ-029 Reset mid-PLAY/WIN/LOSE SHALL abandon the game; no partial state survives.

Configuration
REQ-030 Macro GAME_OUTCOME_SCORE_EN defined: add output score, 16 bits, 4-digit BCD, +1 per accepted alien_hit in PLAY, wraps 9999->0000, cleared on reset and IDLE->PLAY, held in WIN/LOSE.
REQ-031 Macro undefined: no score port, no score logic; all other behaviour identical.

Structure
REQ-032 Package game_pkg SHALL hold the state enum typedef and the 31.5 MHz clock constant.
REQ-033 One sub-module, rise_edge (registered edge detector, reset value parameterised), SHALL provide the start edge.

Verification (NUM_ALIENS=4, NUM_LIVES=2, HOLD_CYCLES=10)
REQ-034 Reset, start edge -> game_active=1, aliens_left=4, lives=2 next cycle.
REQ-035 Four alien_hit pulses -> aliens_left 3,2,1; winner=1 cycle after fourth; game_active=0.
REQ-036 Two player_hit pulses -> lives=1 then loser=1, lives=0; third pulse ignored.
REQ-037 Final alien_hit and player_hit same cycle with lives=1, aliens_left=1 -> loser=1, winner=0.
REQ-038 In WIN, start edge at hold cycle 5 -> stays WIN; edge at cycle 12 -> IDLE, winner=0.
REQ-039 start held high across rst release -> stays IDLE; rst low mid-PLAY -> all outputs 0 immediately.
